// File: rtl/dsp_cfg_pkg.sv
// Shared definitions for the configuration chain loader: FSM encoding and CRC-16 constants.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package dsp_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    VERIFY = 2'd2,
    FINISH = 2'd3
  } cfg_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One MSB-first serial CRC-16 step.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// cfg_crc16_serial: one-bit-per-clock CRC-16 accumulator (poly 0x1021, MSB-first).
// Latency: the CRC register reflects a bit one clock after en_i samples it.
// Backpressure: none; the caller gates en_i.
// Ports: clk/rst_n; init_i loads CRC_INIT; en_i/bit_i feed one bit; crc_o is the running CRC.
module cfg_crc16_serial
  import dsp_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_i,
  input  logic        en_i,
  input  logic        bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc16_step(crc_q, bit_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: shifts a host word stream into a serial configuration chain, optional CRC readback.
// Latency: CHAIN_LEN shifts (plus refill bubbles) in LOAD, CHAIN_LEN cycles in VERIFY, one FINISH cycle.
// Backpressure: s_ready only while the word buffer is empty; a host stall holds configuration_enable low.
// Ports: clk/rst_n; start/verify_en request; s_data/s_valid/s_ready word stream (bit 0 first);
//        configuration_enable/_input/_output chain interface; busy/done/error/crc_out status.
module config_chain_loader
  import dsp_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 4,
  parameter int WORD_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              configuration_enable,
  output logic              configuration_input,
  input  logic              configuration_output,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       crc_out
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BUF_W = $clog2(WORD_W + 1);

  cfg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  shift_cnt_q, shift_cnt_d;  // shifts done in the current phase
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;      // bits taken from the host so far
  logic [WORD_W-1:0] buf_q, buf_d;              // word buffer, bit 0 is next out
  logic [BUF_W-1:0]  buf_cnt_q, buf_cnt_d;      // useful bits left in the buffer
  logic              ce_q, ce_d;
  logic              cin_q, cin_d;
  logic              verify_q, verify_d;
  logic              error_q, error_d;

  logic              start_acc;
  logic              accept;
  logic              crc_mism;
  logic [31:0]       rem_bits;
  logic [31:0]       take_bits;
  logic [15:0]       crc_ld;
  logic [15:0]       crc_rb;

  assign start_acc = (state_q == IDLE) && start;
  assign s_ready   = (state_q == LOAD) && (buf_cnt_q == '0) &&
                     (req_cnt_q < CNT_W'(CHAIN_LEN));
  assign accept    = s_valid && s_ready;

  // Only the bits still needed by the chain are kept from a word; the rest are dropped.
  assign rem_bits  = 32'(CHAIN_LEN) - 32'(req_cnt_q);
  assign take_bits = (rem_bits > 32'(WORD_W)) ? 32'(WORD_W) : rem_bits;

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    req_cnt_d   = req_cnt_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    ce_d        = 1'b0;
    cin_d       = 1'b0;
    verify_d    = verify_q;
    error_d     = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          shift_cnt_d = '0;
          req_cnt_d   = '0;
          buf_cnt_d   = '0;
          verify_d    = verify_en;
          error_d     = 1'b0;
        end
      end
      LOAD: begin
        // ce_q high means the bit in cin_q is shifted at this edge.
        if (ce_q) begin
          shift_cnt_d = shift_cnt_q + CNT_W'(1);
        end
        if (buf_cnt_q != '0) begin
          ce_d      = 1'b1;
          cin_d     = buf_q[0];
          buf_d     = buf_q >> 1;
          buf_cnt_d = buf_cnt_q - BUF_W'(1);
        end else if (accept) begin
          buf_d     = s_data;
          buf_cnt_d = BUF_W'(take_bits);
          req_cnt_d = req_cnt_q + CNT_W'(take_bits);
        end
        if (ce_q && (shift_cnt_q == CNT_W'(CHAIN_LEN - 1))) begin
          shift_cnt_d = '0;
          state_d     = verify_q ? VERIFY : FINISH;
        end
      end
      VERIFY: begin
        shift_cnt_d = shift_cnt_q + CNT_W'(1);
        if (shift_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
          shift_cnt_d = '0;
          state_d     = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        error_d = error_q | crc_mism;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      req_cnt_q   <= '0;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      ce_q        <= 1'b0;
      cin_q       <= 1'b0;
      verify_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      req_cnt_q   <= req_cnt_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      ce_q        <= ce_d;
      cin_q       <= cin_d;
      verify_q    <= verify_d;
      error_q     <= error_d;
    end
  end

  cfg_crc16_serial u_crc_load (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_i (start_acc),
    .en_i   ((state_q == LOAD) && ce_q),
    .bit_i  (cin_q),
    .crc_o  (crc_ld)
  );

  cfg_crc16_serial u_crc_readback (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_i (start_acc),
    .en_i   (state_q == VERIFY),
    .bit_i  (configuration_output),
    .crc_o  (crc_rb)
  );

  assign crc_mism = verify_q && (crc_ld != crc_rb);

  // In VERIFY the tail is fed straight back to the head so the chain rotates once and ends unchanged.
  assign configuration_enable = (state_q == VERIFY) || ((state_q == LOAD) && ce_q);
  assign configuration_input  = (state_q == VERIFY) ? configuration_output : cin_q;
  assign busy                 = (state_q != IDLE);
  assign done                 = (state_q == FINISH);
  assign error                = error_q || ((state_q == FINISH) && crc_mism);
  assign crc_out              = crc_ld;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: two instances (CHAIN_LEN 4 and 20), a chain model per instance,
// a per-cycle monitor checked against a queue-based reference, and directed literal checks.
module tb_config_chain_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        verify_en;
  logic        s_valid;
  logic [15:0] s_data;
  int          sel;
  bit          stuck;

  always #5 clk = ~clk;

  logic        start_a, start_b, s_valid_a, s_valid_b;
  logic        s_ready_a, ce_a, cin_a, cout_a, busy_a, done_a, error_a;
  logic        s_ready_b, ce_b, cin_b, cout_b, busy_b, done_b, error_b;
  logic [15:0] crc_a, crc_b;
  logic [3:0]  chain_a;
  logic [19:0] chain_b;

  assign start_a   = start && (sel == 0);
  assign start_b   = start && (sel != 0);
  assign s_valid_a = s_valid && (sel == 0);
  assign s_valid_b = s_valid && (sel != 0);
  assign cout_a    = (stuck && sel == 0) ? 1'b0 : chain_a[3];
  assign cout_b    = (stuck && sel != 0) ? 1'b0 : chain_b[19];

  always @(posedge clk) if (ce_a) chain_a <= {chain_a[2:0], cin_a};
  always @(posedge clk) if (ce_b) chain_b <= {chain_b[18:0], cin_b};

  config_chain_loader #(.CHAIN_LEN(4), .WORD_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .verify_en(verify_en),
    .s_data(s_data), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .configuration_enable(ce_a), .configuration_input(cin_a),
    .configuration_output(cout_a), .busy(busy_a), .done(done_a),
    .error(error_a), .crc_out(crc_a)
  );

  config_chain_loader #(.CHAIN_LEN(20), .WORD_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .verify_en(verify_en),
    .s_data(s_data), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .configuration_enable(ce_b), .configuration_input(cin_b),
    .configuration_output(cout_b), .busy(busy_b), .done(done_b),
    .error(error_b), .crc_out(crc_b)
  );

  logic        busy, done, error, ce, cin, cout, s_ready;
  logic [15:0] crc_out;
  assign busy    = (sel != 0) ? busy_b    : busy_a;
  assign done    = (sel != 0) ? done_b    : done_a;
  assign error   = (sel != 0) ? error_b   : error_a;
  assign ce      = (sel != 0) ? ce_b      : ce_a;
  assign cin     = (sel != 0) ? cin_b     : cin_a;
  assign cout    = (sel != 0) ? cout_b    : cout_a;
  assign s_ready = (sel != 0) ? s_ready_b : s_ready_a;
  assign crc_out = (sel != 0) ? crc_b     : crc_a;

  // Reference model state for the operation in flight.
  bit          exp_bits[$];
  logic [15:0] m_crc;
  bit          m_err, m_verify, m_stuck;
  int          op_id = 0;
  int          done_cnt = 0;
  int          ops = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [15:0] crc_of(input bit b[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (b[i]) begin
      if (c[15] ^ b[i]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

  // Chain contents viewed as a word: bit i is the i-th bit shifted in.
  function automatic logic [31:0] chain_field();
    logic [31:0] f = '0;
    if (sel != 0) for (int i = 0; i < 20; i++) f[i] = chain_b[19-i];
    else          for (int i = 0; i < 4; i++)  f[i] = chain_a[3-i];
    return f;
  endfunction

  function automatic logic [31:0] exp_field();
    logic [31:0] f = '0;
    foreach (exp_bits[i]) f[i] = exp_bits[i];
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_model(input int s, input logic [15:0] w0, input logic [15:0] w1,
                           input bit vfy, input bit stk);
    int L;
    bit rb[$];
    logic [15:0] w;
    sel = s;
    stuck = stk;
    L = (s != 0) ? 20 : 4;
    exp_bits.delete();
    for (int i = 0; i < L; i++) begin
      w = (i < 16) ? w0 : w1;
      exp_bits.push_back(w[i % 16]);
    end
    for (int i = 0; i < L; i++) rb.push_back(stk ? 1'b0 : exp_bits[i]);
    m_crc    = crc_of(exp_bits);
    m_err    = vfy && (crc_of(rb) != m_crc);
    m_verify = vfy;
    m_stuck  = stk;
    op_id++;
  endtask

  task automatic monitor();
    int  seen_op = -1;
    int  nsh = 0;
    int  nacc = 0;
    bit  prev_done = 0;
    int  L;
    forever begin
      @(negedge clk);
      L = (sel != 0) ? 20 : 4;
      if (!rst_n) begin
        prev_done = 0;
      end else begin
        if (prev_done) begin
          check("busy_fall", {busy, done}, 2'b00);
          check("error_sticky", error, m_err);
        end
        prev_done = done;
        if (op_id != seen_op) begin
          seen_op = op_id;
          nsh = 0;
          nacc = 0;
        end
        if (!busy) check("idle_quiet", {ce, s_ready, done}, 3'b000);
        if (busy && !done) check("error_busy", error, 1'b0);
        if (ce) begin
          if (nsh < L) begin
            check("bit_avail", (nsh < nacc * 16), 1'b1);
            check("load_bit", cin, exp_bits[nsh]);
          end else if (m_verify && nsh < 2 * L) begin
            check("recirc", cin, cout);
          end else begin
            check("extra_shift", nsh, m_verify ? 2 * L : L);
          end
          nsh++;
        end else if (busy && m_verify && nsh >= L && nsh < 2 * L) begin
          check("verify_gap", ce, 1'b1);
        end
        if (s_ready) begin
          check("ready_need", (nacc * 16 < L), 1'b1);
          if (s_valid) nacc++;
        end
        if (done) begin
          check("shifts_at_done", nsh, m_verify ? 2 * L : L);
          check("crc_out", crc_out, m_crc);
          check("error_at_done", error, m_err);
          if (!m_stuck) check("chain", chain_field(), exp_field());
          done_cnt++;
        end
      end
    end
  endtask

  task automatic run_op(input int s, input logic [15:0] w0, input logic [15:0] w1,
                        input bit vfy, input bit stk, input int gmin, input int gmax,
                        input bit hold);
    int L, nwords, gap, t;
    set_model(s, w0, w1, vfy, stk);
    L = (s != 0) ? 20 : 4;
    nwords = (L + 15) / 16;
    start = 1'b1;
    verify_en = vfy;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    verify_en = !vfy;
    for (int k = 0; k < nwords; k++) begin
      s_data = (k == 0) ? w0 : w1;
      s_valid = 1'b1;
      for (t = 0; t < 200; t++) begin
        @(negedge clk);
        if (s_ready) break;
      end
      if (!s_ready) begin
        check("ready_timeout", s_ready, 1'b1);
        s_valid = 1'b0;
        start = 1'b0;
        return;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data = 16'($urandom);
      gap = $urandom_range(gmax, gmin);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
    if (!done) check("done_timeout", done, 1'b1);
    else ops++;
    @(negedge clk);
    @(posedge clk); #1;
    check("done_count", done_cnt, ops);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    bit          q[$];
    logic [31:0] f;
    logic [15:0] w0, w1;
    int          cnt, saved;

    rst_n = 1'b0; start = 1'b0; verify_en = 1'b0; s_valid = 1'b0;
    s_data = 16'h0000; sel = 0; stuck = 1'b0;
    fork monitor(); join_none

    // Model pins: CRC of bit streams 1,1,0,1 and 1,0,1,0 worked by hand.
    q = '{1'b1, 1'b1, 1'b0, 1'b1};
    check("model_crc_B", crc_of(q), 16'hDFB2);
    q = '{1'b1, 1'b0, 1'b1, 1'b0};
    check("model_crc_5", crc_of(q), 16'hAF55);

    repeat (2) @(posedge clk); #1;
    check("rst_busy", busy, 1'b0);
    check("rst_ce", ce, 1'b0);
    check("rst_cin", cin, 1'b0);
    check("rst_ready", s_ready, 1'b0);
    check("rst_done_err", {done, error}, 2'b00);
    check("rst_crc", crc_out, 16'h0000);
    sel = 1; #1;
    check("rst_b_outputs", {busy, ce, cin, s_ready, done, error}, 6'd0);
    check("rst_b_crc", crc_out, 16'h0000);
    sel = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four-bit chain with 0x000B.
    run_op(0, 16'h000B, 16'h0000, 1'b0, 1'b0, 0, 0, 1'b0);
    check("B_crc_literal", crc_out, 16'hDFB2);
    f = chain_field();
    check("B_chain", f[3:0], 4'b1011);
    check("is_rstp_inverted", f[0], 1'b1);
    check("autoreset_priority", f[1], 1'b1);
    check("autoreset_patdet", f[3:2], 2'b10);

    // Twenty-bit chain, three-cycle host stall, upper 12 bits of word 2 set.
    w0 = 16'($urandom);
    w1 = 16'hFFF0 | 16'($urandom_range(15, 0));
    run_op(1, w0, w1, 1'b0, 1'b0, 3, 3, 1'b0);
    f = chain_field();
    check("stall_chain", f[19:0], {w1[3:0], w0});

    // Verify pass with 0x0005.
    run_op(0, 16'h0005, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0);
    check("v5_crc_literal", crc_out, 16'hAF55);
    check("v5_error", error, 1'b0);
    f = chain_field();
    check("v5_chain", f[3:0], 4'b0101);

    // Stuck-at-0 tail: error set, sticky, then cleared by the next start.
    run_op(0, 16'h000F, 16'h0000, 1'b1, 1'b1, 0, 0, 1'b0);
    check("stuck_error", error, 1'b1);
    run_op(0, 16'($urandom), 16'h0000, 1'b1, 1'b0, 0, 2, 1'b0);
    check("error_cleared", error, 1'b0);

    // Start held high throughout an operation.
    run_op(0, 16'($urandom), 16'h0000, 1'b1, 1'b0, 0, 1, 1'b1);
    run_op(1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 0, 2, 1'b1);

    // Reset after two load shifts.
    w0 = 16'($urandom);
    set_model(0, w0, 16'h0000, 1'b0, 1'b0);
    s_data = w0; s_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    for (int t = 0; t < 50 && cnt < 2; t++) begin
      @(negedge clk);
      if (ce) cnt++;
    end
    check("pre_reset_shifts", cnt, 2);
    @(posedge clk); #2;
    saved = done_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ce_cin", {ce, cin}, 2'b00);
    check("mid_rst_ready_done_err", {s_ready, done, error}, 3'b000);
    check("mid_rst_crc", crc_out, 16'h0000);
    s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_done_after_rst", done_cnt, saved);
    @(posedge clk); #1;
    run_op(0, 16'($urandom), 16'h0000, 1'b1, 1'b0, 0, 1, 1'b0);

    // Randomized operations across both chain lengths.
    for (int n = 0; n < 24; n++) begin
      run_op($urandom_range(1, 0), 16'($urandom), 16'($urandom),
             1'($urandom_range(1, 0)), ($urandom_range(4, 0) == 0),
             0, $urandom_range(3, 0), ($urandom_range(5, 0) == 0));
    end
    stuck = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 4, meaning the number of serial configuration bits in the target chain (range 1..4096).
REQ-002 SHALL have parameter WORD_W, default 16, meaning the host word width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: load request, sampled in IDLE only.
REQ-006 SHALL have port verify_en, input, 1 bit: readback-check request, captured on the accepted start.
REQ-007 SHALL have port s_data, input, WORD_W bits: configuration bitstream word; bit 0 is shifted first.
REQ-008 SHALL have port s_valid, input, 1 bit: s_data is valid.
REQ-009 SHALL have port s_ready, output, 1 bit: loader accepts s_data this cycle.
REQ-010 SHALL have port configuration_enable, output, 1 bit: chain shift enable.
REQ-011 SHALL have port configuration_input, output, 1 bit: serial data into the chain head.
REQ-012 SHALL have port configuration_output, input, 1 bit: serial data from the chain tail.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE; the datapath holds its CE low while busy.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port error, output, 1 bit: readback CRC mismatch, sticky until the next accepted start.
REQ-016 SHALL have port crc_out, output, 16 bits: CRC of the bits loaded in the last operation.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, VERIFY and FINISH; transitions: IDLE->LOAD on start; LOAD->VERIFY after CHAIN_LEN shifts when verify_en was captured, else LOAD->FINISH; VERIFY->FINISH after CHAIN_LEN shifts; FINISH->IDLE unconditionally.
REQ-018 SHALL, on accepting start, clear the shift counter, set the CRC to 0xFFFF and clear error.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL assert s_ready only in LOAD, and only when the word buffer is empty and fewer than CHAIN_LEN bits have been requested.
REQ-021 SHALL accept a word only on a cycle where s_valid and s_ready are both high.
REQ-022 SHALL, in LOAD, drive configuration_enable high only on cycles where a buffered bit is presented on configuration_input; a host stall holds enable low so the chain retains its contents.
REQ-023 SHALL count one shift per rising edge with configuration_enable high.
REQ-024 SHALL discard the unused bits of the final word when CHAIN_LEN is not a multiple of WORD_W.
REQ-025 SHALL drive configuration_enable and configuration_input from flops in LOAD, with no combinational path from s_data.
REQ-026 SHALL update the CRC in LOAD with each shifted bit: polynomial 0x1021, MSB-first serial update.
REQ-027 SHALL, in VERIFY, hold configuration_enable high for exactly CHAIN_LEN consecutive cycles and drive configuration_input = configuration_output combinationally, so the chain recirculates and ends unchanged.
REQ-028 SHALL, in VERIFY, compute a second CRC over configuration_output sampled on each shift edge.
REQ-029 SHALL, in FINISH, pulse done for 1 cycle, set error when verify was captured and the two CRCs differ, and present the load CRC on crc_out.
REQ-030 SHALL hold configuration_enable low in IDLE and FINISH.

Reset
REQ-031 SHALL, on rst_n low, immediately force state=IDLE, configuration_enable=0, configuration_input=0, s_ready=0, busy=0, done=0, error=0, crc_out=0x0000, and clear the counter and word buffer.
REQ-032 SHALL, on reset mid-LOAD or mid-VERIFY, abort the operation with no done pulse; chain contents are undefined and the host reloads.

Structure
REQ-033 SHALL place the FSM state encoding, CRC_POLY=16'h1021 and CRC_INIT=16'hFFFF in a shared package, dsp_cfg_pkg.
REQ-034 SHALL implement the serial CRC-16 update in one sub-module, cfg_crc16_serial, instantiated twice (load and readback).

Verification
REQ-035 SHALL be checked with CHAIN_LEN=4, start, s_data=0x000B -> 4 shifts; chain holds IS_RSTP_INVERTED=1, AUTORESET_PRIORITY=1, AUTORESET_PATDET=2'b10; done pulses once; busy falls with done.
REQ-036 SHALL be checked with CHAIN_LEN=20, WORD_W=16, s_valid low for 3 cycles between words -> configuration_enable low during the stall, exactly 20 shifts, upper 12 bits of word 2 ignored.
REQ-037 SHALL be checked with CHAIN_LEN=4, verify_en=1, data 0x0005 -> 4 recirculation cycles, chain still 0101 afterwards, error=0, both CRCs equal.
REQ-038 SHALL be checked with the chain model tail forced stuck-at-0 and verify_en=1, data 0x000F -> error=1 at done; error clears on the next accepted start.
REQ-039 SHALL be checked with rst_n pulsed low after 2 shifts -> all outputs at reset values within the same cycle, no done pulse, next start loads normally.
REQ-040 SHALL be checked with start held high during LOAD -> no restart; exactly one done pulse per operation.
